// File: rtl/fft_sym_ctrl_if.sv
// Sample, FFT and bin stream signals between the symbol sequencer and its neighbours.
interface fft_sym_ctrl_if #(
    parameter int unsigned width = 11
);
    // Input sample stream and symbol framing
    logic [5:0]       gi_len;
    logic             sym_start;
    logic             in_valid;
    logic [width-1:0] in_r;
    logic [width-1:0] in_i;

    // FFT core input port
    logic             fft_valid_a;
    logic [width-1:0] fft_ar;
    logic [width-1:0] fft_ai;

    // FFT core result port
    logic             fft_valid_o;
    logic [width-1:0] fft_xr;
    logic [width-1:0] fft_xi;

    // Tagged bin output
    logic             out_valid;
    logic [width-1:0] out_r;
    logic [width-1:0] out_i;
    logic [5:0]       out_idx;
    logic             out_last;

    // Status and sticky errors
    logic             busy;
    logic [7:0]       frame_cnt;
    logic             err_overrun;
    logic             err_timeout;
    logic             err_short;
    logic             err_clr;

    modport master (
        output gi_len, sym_start, in_valid, in_r, in_i,
        output fft_valid_o, fft_xr, fft_xi, err_clr,
        input  fft_valid_a, fft_ar, fft_ai,
        input  out_valid, out_r, out_i, out_idx, out_last,
        input  busy, frame_cnt, err_overrun, err_timeout, err_short
    );

    modport slave (
        input  gi_len, sym_start, in_valid, in_r, in_i,
        input  fft_valid_o, fft_xr, fft_xi, err_clr,
        output fft_valid_a, fft_ar, fft_ai,
        output out_valid, out_r, out_i, out_idx, out_last,
        output busy, frame_cnt, err_overrun, err_timeout, err_short
    );
endinterface

// File: rtl/fft_sym_ctrl.sv
// Symbol sequencer around a 64-point FFT: drops the guard interval, feeds 64 samples,
// then tags the 64-bin result burst with index/last and flags overrun, timeout, short burst.
module fft_sym_ctrl #(
    parameter int unsigned width = 11,
    parameter int unsigned TMO   = 1023
) (
    input  logic          CLK,
    input  logic          RST,
    fft_sym_ctrl_if.slave bus
);
    localparam int unsigned     TmoW    = $clog2(TMO + 1);
    // Last WAIT cycle: the counter would reach TMO on the next increment.
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TMO - 1);

    typedef enum logic [2:0] {StIdle, StSkip, StLoad, StWait, StDrain} state_e;

    state_e          r_state, w_state_d;
    logic [5:0]      r_cnt, w_cnt_d;
    logic [5:0]      r_gi_len, w_gi_d;
    logic [TmoW-1:0] r_tmo, w_tmo_d;

    logic w_start;
    logic w_fwd;
    logic w_emit;
    logic w_emit_last;
    logic w_set_overrun;
    logic w_set_timeout;
    logic w_set_short;

    logic             r_fft_valid_a;
    logic [width-1:0] r_fft_ar;
    logic [width-1:0] r_fft_ai;
    logic             r_out_valid;
    logic [width-1:0] r_out_r;
    logic [width-1:0] r_out_i;
    logic [5:0]       r_out_idx;
    logic             r_out_last;
    logic             r_busy;
    logic [7:0]       r_frame_cnt;
    logic             r_err_overrun;
    logic             r_err_timeout;
    logic             r_err_short;

    // A symbol start is accepted only before loading has begun.
    assign w_start = bus.sym_start && (r_state == StIdle || r_state == StSkip);

    // State, sample/bin counter, latched guard length and timeout counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_gi_len <= '0;
            r_tmo    <= '0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_gi_len <= w_gi_d;
            r_tmo    <= w_tmo_d;
        end
    end

    // Next-state and counter update; a sample arriving with the start marker is sample 0.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_gi_d    = r_gi_len;
        w_tmo_d   = r_tmo;
        if (w_start) begin
            w_gi_d = bus.gi_len;
            if (bus.gi_len == 6'd0) begin
                w_state_d = StLoad;
                w_cnt_d   = bus.in_valid ? 6'd1 : 6'd0;
            end else if (bus.in_valid && bus.gi_len == 6'd1) begin
                w_state_d = StLoad;
                w_cnt_d   = 6'd0;
            end else begin
                w_state_d = StSkip;
                w_cnt_d   = bus.in_valid ? 6'd1 : 6'd0;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                end
                StSkip: begin
                    if (bus.in_valid) begin
                        if (r_cnt + 6'd1 == r_gi_len) begin
                            w_state_d = StLoad;
                            w_cnt_d   = 6'd0;
                        end else begin
                            w_cnt_d = r_cnt + 6'd1;
                        end
                    end
                end
                StLoad: begin
                    if (bus.in_valid) begin
                        if (r_cnt == 6'd63) begin
                            w_state_d = StWait;
                            w_cnt_d   = 6'd0;
                            w_tmo_d   = '0;
                        end else begin
                            w_cnt_d = r_cnt + 6'd1;
                        end
                    end
                end
                StWait: begin
                    if (bus.fft_valid_o) begin
                        w_state_d = StDrain;
                        w_cnt_d   = 6'd1;
                    end else if (r_tmo == TmoLast) begin
                        w_state_d = StIdle;
                    end else begin
                        w_tmo_d = r_tmo + 1'b1;
                    end
                end
                StDrain: begin
                    if (bus.fft_valid_o && r_cnt != 6'd63) begin
                        w_cnt_d = r_cnt + 6'd1;
                    end else begin
                        w_state_d = StIdle;
                        w_cnt_d   = 6'd0;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    // Per-cycle strobes and error events decoded from the current state.
    always_comb begin
        w_fwd         = bus.in_valid &&
                        (r_state == StLoad || (w_start && bus.gi_len == 6'd0));
        w_emit        = bus.fft_valid_o && (r_state == StWait || r_state == StDrain);
        w_emit_last   = bus.fft_valid_o && r_state == StDrain && r_cnt == 6'd63;
        w_set_overrun = bus.sym_start &&
                        (r_state == StLoad || r_state == StWait || r_state == StDrain);
        w_set_timeout = r_state == StWait && !bus.fft_valid_o && r_tmo == TmoLast;
        w_set_short   = r_state == StDrain && !bus.fft_valid_o;
    end

    // Registered FFT input, bin output, status and sticky error flags (set beats clear).
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fft_valid_a <= 1'b0;
            r_fft_ar      <= '0;
            r_fft_ai      <= '0;
            r_out_valid   <= 1'b0;
            r_out_r       <= '0;
            r_out_i       <= '0;
            r_out_idx     <= '0;
            r_out_last    <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_cnt   <= '0;
            r_err_overrun <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_short   <= 1'b0;
        end else begin
            r_fft_valid_a <= w_fwd;
            if (w_fwd) begin
                r_fft_ar <= bus.in_r;
                r_fft_ai <= bus.in_i;
            end
            r_out_valid <= w_emit;
            r_out_last  <= w_emit_last;
            if (w_emit) begin
                r_out_r   <= bus.fft_xr;
                r_out_i   <= bus.fft_xi;
                r_out_idx <= r_cnt;
            end
            r_busy <= (r_state != StIdle);
            if (w_emit_last) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            r_err_overrun <= w_set_overrun | (r_err_overrun & ~bus.err_clr);
            r_err_timeout <= w_set_timeout | (r_err_timeout & ~bus.err_clr);
            r_err_short   <= w_set_short   | (r_err_short   & ~bus.err_clr);
        end
    end

    assign bus.fft_valid_a = r_fft_valid_a;
    assign bus.fft_ar      = r_fft_ar;
    assign bus.fft_ai      = r_fft_ai;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_r       = r_out_r;
    assign bus.out_i       = r_out_i;
    assign bus.out_idx     = r_out_idx;
    assign bus.out_last    = r_out_last;
    assign bus.busy        = r_busy;
    assign bus.frame_cnt   = r_frame_cnt;
    assign bus.err_overrun = r_err_overrun;
    assign bus.err_timeout = r_err_timeout;
    assign bus.err_short   = r_err_short;
endmodule

// File: tb/tb_fft_sym_ctrl.sv
// Directed bench for fft_sym_ctrl: guard skip, drain, gaps, timeout, overrun, short, reset.
module tb_fft_sym_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cnt;
    int   bad;

    always #5 clk = ~clk;

    fft_sym_ctrl_if #(.width(11)) bus ();

    fft_sym_ctrl #(.width(11), .TMO(1023)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.gi_len      = 6'd0;
        bus.sym_start   = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_r        = '0;
        bus.in_i        = '0;
        bus.fft_valid_o = 1'b0;
        bus.fft_xr      = '0;
        bus.fft_xi      = '0;
        bus.err_clr     = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_frame_cnt", 32'(bus.frame_cnt), 0);
        check("reset_strobes", 32'({bus.fft_valid_a, bus.out_valid, bus.out_last}), 0);

        // Guard skip: gi_len=16, 80 back-to-back samples, expect 16..79 forwarded
        cnt = 0;
        bad = 0;
        for (int n = 0; n < 80; n++) begin
            bus.gi_len    = 6'd16;
            bus.sym_start = (n == 0);
            bus.in_valid  = 1'b1;
            bus.in_r      = 11'(n);
            bus.in_i      = 11'(n + 500);
            step();
            if (bus.fft_valid_a) begin
                if (bus.fft_ar !== 11'(cnt + 16) || bus.fft_ai !== 11'(cnt + 516)) bad++;
                cnt++;
            end
        end
        bus.sym_start = 1'b0;
        bus.in_valid  = 1'b0;
        check("guard_fwd_count", 32'(cnt), 64);
        check("guard_fwd_data", 32'(bad), 0);
        check("guard_last_ar", 32'(bus.fft_ar), 79);
        check("guard_busy", 32'(bus.busy), 1);
        check("guard_no_err", 32'({bus.err_overrun, bus.err_timeout, bus.err_short}), 0);
        step();
        check("guard_no_extra", 32'(bus.fft_valid_a), 0);

        // Result drain: 64 bins, out_r = out_idx = k
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            bus.fft_valid_o = 1'b1;
            bus.fft_xr      = 11'(k);
            bus.fft_xi      = 11'(k + 1000);
            step();
            if (!bus.out_valid || bus.out_r !== 11'(k) || bus.out_i !== 11'(k + 1000) ||
                bus.out_idx !== 6'(k) || bus.out_last !== (k == 63)) bad++;
        end
        check("drain_bins", 32'(bad), 0);
        check("drain_last", 32'(bus.out_last), 1);
        check("drain_frame_cnt", 32'(bus.frame_cnt), 1);
        check("drain_busy_lag", 32'(bus.busy), 1);
        bus.fft_xr = 11'd64;
        step();
        check("drain_extra_ignored", 32'({bus.out_valid, bus.out_last}), 0);
        check("drain_busy_low", 32'(bus.busy), 0);
        check("drain_no_short", 32'(bus.err_short), 0);
        bus.fft_valid_o = 1'b0;

        // Zero guard, in_valid every other cycle: each pulse one cycle after its sample
        cnt = 0;
        bad = 0;
        for (int c = 0; c < 128; c++) begin
            bus.gi_len    = 6'd0;
            bus.sym_start = (c == 0);
            bus.in_valid  = (c % 2 == 0);
            bus.in_r      = 11'(c / 2 + 200);
            step();
            if (bus.fft_valid_a !== (c % 2 == 0)) bad++;
            if (bus.fft_valid_a) begin
                if (bus.fft_ar !== 11'(cnt + 200)) bad++;
                cnt++;
            end
        end
        bus.sym_start = 1'b0;
        bus.in_valid  = 1'b0;
        check("gap_fwd_count", 32'(cnt), 64);
        check("gap_align_data", 32'(bad), 0);

        // Timeout: 1023 WAIT cycles without results (one already elapsed above)
        repeat (1021) step();
        check("tmo_not_yet", 32'(bus.err_timeout), 0);
        check("tmo_still_busy", 32'(bus.busy), 1);
        step();
        check("tmo_flag", 32'(bus.err_timeout), 1);
        check("tmo_frame_cnt", 32'(bus.frame_cnt), 1);
        step();
        check("tmo_idle", 32'(bus.busy), 0);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("tmo_clear", 32'(bus.err_timeout), 0);

        // Overrun: second sym_start after 30 loaded samples is ignored
        cnt = 0;
        bad = 0;
        for (int n = 0; n < 66; n++) begin
            bus.gi_len    = 6'd2;
            bus.sym_start = (n == 0 || n == 32);
            bus.in_valid  = 1'b1;
            bus.in_r      = 11'(n);
            step();
            if (bus.fft_valid_a) begin
                if (bus.fft_ar !== 11'(cnt + 2)) bad++;
                cnt++;
            end
        end
        bus.in_valid = 1'b0;
        check("ovr_fwd_count", 32'(cnt), 64);
        check("ovr_fwd_data", 32'(bad), 0);
        check("ovr_flag", 32'(bus.err_overrun), 1);
        // sym_start in WAIT with err_clr in the same cycle: set wins
        bus.sym_start = 1'b1;
        bus.err_clr   = 1'b1;
        step();
        bus.sym_start = 1'b0;
        check("ovr_set_beats_clr", 32'(bus.err_overrun), 1);
        step();
        bus.err_clr = 1'b0;
        check("ovr_clear", 32'(bus.err_overrun), 0);
        check("ovr_wait_busy", 32'(bus.busy), 1);

        // Short burst: 10 result cycles then a gap
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            bus.fft_valid_o = 1'b1;
            bus.fft_xr      = 11'(k + 40);
            step();
            if (!bus.out_valid || bus.out_r !== 11'(k + 40) || bus.out_idx !== 6'(k) ||
                bus.out_last) bad++;
        end
        bus.fft_valid_o = 1'b0;
        check("short_bins", 32'(bad), 0);
        check("short_no_flag_yet", 32'(bus.err_short), 0);
        step();
        check("short_flag", 32'(bus.err_short), 1);
        check("short_frame_cnt", 32'(bus.frame_cnt), 1);
        check("short_out_valid", 32'(bus.out_valid), 0);
        step();
        check("short_idle", 32'(bus.busy), 0);

        // Reset mid-LOAD
        for (int n = 0; n < 10; n++) begin
            bus.gi_len    = 6'd0;
            bus.sym_start = (n == 0);
            bus.in_valid  = 1'b1;
            bus.in_r      = 11'(n + 700);
            bus.in_i      = 11'(n + 5);
            step();
        end
        bus.sym_start = 1'b0;
        bus.in_valid  = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_in_path", 32'({bus.fft_valid_a, bus.fft_ar, bus.fft_ai}), 0);
        check("rst_out_path",
              32'({bus.out_valid, bus.out_r, bus.out_i, bus.out_idx, bus.out_last}), 0);
        check("rst_status", 32'({bus.busy, bus.frame_cnt, bus.err_overrun, bus.err_timeout,
                                 bus.err_short}), 0);
        // Samples without a start marker must be ignored in IDLE
        cnt = 0;
        for (int n = 0; n < 3; n++) begin
            bus.in_valid = 1'b1;
            bus.in_r     = 11'(n + 900);
            step();
            if (bus.fft_valid_a) cnt++;
        end
        check("rst_idle_ignores", 32'(cnt), 0);

        // Next symbol after reset: gi_len=8 forwards 8..71
        cnt = 0;
        bad = 0;
        for (int n = 0; n < 72; n++) begin
            bus.gi_len    = 6'd8;
            bus.sym_start = (n == 0);
            bus.in_valid  = 1'b1;
            bus.in_r      = 11'(n);
            step();
            if (bus.fft_valid_a) begin
                if (bus.fft_ar !== 11'(cnt + 8)) bad++;
                cnt++;
            end
        end
        bus.sym_start = 1'b0;
        bus.in_valid  = 1'b0;
        check("gi8_fwd_count", 32'(cnt), 64);
        check("gi8_fwd_data", 32'(bad), 0);
        check("gi8_last_ar", 32'(bus.fft_ar), 71);
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            bus.fft_valid_o = 1'b1;
            bus.fft_xr      = 11'(-(k + 1));
            step();
            if (!bus.out_valid || bus.out_r !== 11'(-(k + 1)) || bus.out_idx !== 6'(k)) bad++;
        end
        bus.fft_valid_o = 1'b0;
        check("gi8_bins", 32'(bad), 0);
        check("gi8_last_value", 32'(bus.out_r), 32'h7C0);
        check("gi8_frame_cnt", 32'(bus.frame_cnt), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
